mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: DATA_W, 32, data width; ADDR_W, 32, address width; MEM_LAT, 1, read latency in cycles from mem_en to valid mem_rdata (legal 1..7).
REQ-002 Ports (name direction width meaning) SHALL be:
  clk  in  1  sole clock, rising edge
  rst  in  1  reset, asynchronous, active-high
  cpu_req  in  1  CPU request, held until cpu_ack
  cpu_we  in  1  CPU write=1 / read=0
  cpu_addr  in  ADDR_W  CPU address
  cpu_wdata  in  DATA_W  CPU write data
  cpu_rdata  out  DATA_W  CPU read data, registered
  cpu_ack  out  1  CPU completion pulse
  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack  same as cpu_* for the debug/loader port
  mem_en  out  1  memory access strobe
  mem_we  out  1  memory write enable
  mem_addr  out  ADDR_W  memory address
  mem_wdata  out  DATA_W  memory write data
  mem_rdata  in  DATA_W  memory read data
  gnt  out  2  one-hot owner: [0]=CPU, [1]=DBG, 00 when idle
  busy  out  1  high in every state except IDLE

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, DONE; one transaction in flight at most.
REQ-004 IDLE: any req high -> latch owner, we, addr, wdata into internal registers; next ISSUE; no req -> stay IDLE.
REQ-005 Arbitration SHALL be round-robin: both req high in IDLE -> grant the port not granted last; single req -> grant it.
REQ-006 last-grant register SHALL update on each grant; reset value = DBG, so CPU wins the first contended cycle.
REQ-007 ISSUE (exactly one cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values; write -> DONE; read -> WAIT with wait counter loaded to MEM_LAT.
REQ-008 mem_en and mem_we SHALL be 0 in every state except ISSUE; mem_we never 1 while mem_en=0.
REQ-009 WAIT: counter decrements each cycle; at counter=1, capture mem_rdata into owner's rdata register on that edge and go to DONE; WAIT lasts exactly MEM_LAT cycles.
REQ-010 DONE (exactly one cycle): owner's ack=1, other ack=0; next IDLE; req inputs SHALL NOT be sampled in DONE.
REQ-011 Timing with request seen in IDLE cycle 0: write ack in cycle 2; read ack in cycle 2+MEM_LAT (MEM_LAT=1 -> cycle 3).
REQ-012 Requester SHALL drop req on the cycle after seeing ack; req high in IDLE is always a new request.
REQ-013 req deasserted or addr/we/wdata changed mid-transaction SHALL NOT affect it: latched values used, ack still pulses.
REQ-014 cpu_rdata/dbg_rdata SHALL change only on completion of a read by that port; writes and the other port's reads leave them unchanged.
REQ-015 gnt SHALL show the latched owner from ISSUE through DONE, 00 in IDLE.
REQ-016 Non-owner port SHALL see no ack and no rdata change while waiting; its held req is served in the next IDLE cycle.

Reset
REQ-017 rst=1 SHALL asynchronously force: state IDLE, last-grant=DBG, wait counter=0, all latched regs=0, cpu_rdata=dbg_rdata=0, cpu_ack=dbg_ack=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, gnt=00, busy=0.
REQ-018 rst asserted mid-transaction SHALL abort it with no ack; after release the requester re-presents req and it is served from IDLE.

Verification
REQ-019 MEM_LAT=1, single CPU read addr 0x10, mem model returns 0xDEADBEEF -> mem_en one cycle, cpu_ack in cycle 3, cpu_rdata=0xDEADBEEF.
REQ-020 DBG write addr 0x40 data 0x12345678 -> mem_en=mem_we=1 one cycle with those values, dbg_ack in cycle 2, cpu_rdata/dbg_rdata unchanged.
REQ-021 cpu_req and dbg_req high together from reset, held continuously (re-raised after each ack) -> grants alternate CPU, DBG, CPU, DBG; no port starves.
REQ-022 MEM_LAT=4 DBG read -> WAIT exactly 4 cycles, dbg_ack in cycle 6, data captured from 4th cycle after ISSUE.
REQ-023 rst pulsed during WAIT of a CPU read -> all outputs per REQ-017 immediately, no cpu_ack; re-issued read completes normally.
REQ-024 CPU changes cpu_addr and drops cpu_req during WAIT -> mem_addr held at original, cpu_ack still pulses once.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/debug arbiter for a single-port memory with fixed read latency.
module mem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        gnt,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, owner_q, owner_d, we_q, we_d, pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic [2:0] cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    owner_d = owner_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    // owner bit: 0 = CPU, 1 = DBG; contention goes to whoever was not granted last
    pick = (cpu_req && dbg_req) ? ~last_q : dbg_req;
    case (state_q)
      IDLE: if (cpu_req || dbg_req) begin
        state_d = ISSUE;
        owner_d = pick;
        last_d = pick;
        we_d = pick ? dbg_we : cpu_we;
        addr_d = pick ? dbg_addr : cpu_addr;
        wdata_d = pick ? dbg_wdata : cpu_wdata;
      end
      ISSUE: begin
        state_d = we_q ? DONE : WAIT;
        cnt_d = we_q ? 3'd0 : 3'(MEM_LAT);
      end
      WAIT: if (cnt_q == 3'd1) begin
        state_d = DONE;
        cnt_d = 3'd0;
        cpu_rdata_d = owner_q ? cpu_rdata_q : mem_rdata;
        dbg_rdata_d = owner_q ? mem_rdata : dbg_rdata_q;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      owner_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= 3'd0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      owner_q <= owner_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end
  assign mem_en = state_q == ISSUE;
  assign mem_we = mem_en && we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack = state_q == DONE && !owner_q;
  assign dbg_ack = state_q == DONE && owner_q;
  assign gnt = state_q == IDLE ? 2'b00 : {owner_q, ~owner_q};
  assign busy = state_q != IDLE;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a latency-accurate memory model.
module tb_mem_arbiter;
  localparam int L = 4;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;} exp_t;
  logic clk = 0, rst = 1;
  logic [1:0] req = 0, we_i = 0, ack, gnt;
  logic [31:0] addr_i [2], wdata_i [2];
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_en, mem_we, busy, cpu_ack, dbg_ack;
  logic [31:0] pmem [logic [31:0]];
  logic [31:0] mdl [logic [31:0]];
  logic [31:0] pipe [L];
  exp_t q [2][$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign ack = {dbg_ack, cpu_ack};
  assign mem_rdata = pipe[L-1];
  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(req[0]), .cpu_we(we_i[0]), .cpu_addr(addr_i[0]), .cpu_wdata(wdata_i[0]),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(req[1]), .dbg_we(we_i[1]), .dbg_addr(addr_i[1]), .dbg_wdata(wdata_i[1]),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .gnt(gnt), .busy(busy)
  );
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction
  function automatic logic [31:0] pm_rd(input logic [31:0] a);
    return pmem.exists(a) ? pmem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] md_rd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : init_val(a);
  endfunction
  // memory: read data is valid only in the L-th cycle after the strobe, junk otherwise
  always @(posedge clk) begin
    if (mem_en && mem_we) pmem[mem_addr] = mem_wdata;
    for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= (mem_en && !mem_we) ? pm_rd(mem_addr) : $urandom;
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic do_txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d, input bit mess);
    exp_t e;
    bit ok = 0;
    e.we = w; e.addr = a; e.wdata = d; e.rdata = w ? 32'h0 : md_rd(a);
    if (w) mdl[a] = d;
    q[p].push_back(e);
    req[p] = 1; we_i[p] = w; addr_i[p] = a; wdata_i[p] = d;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk); #1;
      if (ack[p]) ok = 1;
      else if (mess && gnt[p]) begin
        req[p] = 0; we_i[p] = ~w; addr_i[p] = $urandom; wdata_i[p] = $urandom;
      end
    end
    req[p] = 0;
    if (!ok) chk($sformatf("ack_timeout_p%0d", p), 0, 1);
  endtask
  task automatic rand_txns(input int p, input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      do_txn(p, 1'($urandom), (p ? 32'h100 : 32'h0) + {24'h0, 6'($urandom), 2'b00},
             $urandom, $urandom_range(0, 3) == 0);
    end
  endtask
  task automatic rst_checks(input string n);
    chk({n, "_cpu_rdata"}, cpu_rdata, 0);
    chk({n, "_dbg_rdata"}, dbg_rdata, 0);
    chk({n, "_mem_addr"}, mem_addr, 0);
    chk({n, "_mem_wdata"}, mem_wdata, 0);
    chk({n, "_ctrl"}, {cpu_ack, dbg_ack, mem_en, mem_we, gnt, busy}, 0);
  endtask
  // monitor: arbitration, strobe contents, ack latency and rdata stability
  int cyc = 0, gstart = 0, en_cnt = 0;
  logic last_g = 1, own = 0, prev_busy = 0;
  logic [1:0] prev_req = 0;
  logic [31:0] last_rd [2] = '{0, 0};
  always @(negedge clk) begin
    exp_t e;
    logic eo;
    if (rst) begin
      q[0].delete(); q[1].delete();
      last_g = 1; last_rd[0] = 0; last_rd[1] = 0; prev_busy = 0; prev_req = 0; cyc = 0;
    end else begin
      cyc++;
      if (!prev_busy && prev_req != 0) begin
        eo = (prev_req == 2'b11) ? ~last_g : prev_req[1];
        chk("arb_gnt", gnt, eo ? 2'b10 : 2'b01);
        last_g = eo; own = eo; gstart = cyc - 1; en_cnt = 0;
      end else if (busy) chk("gnt_hold", gnt, own ? 2'b10 : 2'b01);
      if (!busy) chk("gnt_idle", gnt, 0);
      chk("busy_vs_gnt", busy, gnt != 0);
      chk("we_without_en", mem_we && !mem_en, 0);
      chk("ack_both", ack == 2'b11, 0);
      if (mem_en) begin
        en_cnt++;
        if (q[own].size() == 0) chk("strobe_unexpected", 1, 0);
        else begin
          e = q[own][0];
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        end
      end
      for (int p = 0; p < 2; p++) if (ack[p]) begin
        chk("ack_owner", p, own);
        if (q[p].size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          e = q[p].pop_front();
          chk("ack_latency", cyc - gstart, e.we ? 2 : 2 + L);
          chk("strobe_count", en_cnt, 1);
          if (!e.we) last_rd[p] = e.rdata;
        end
      end
      chk("cpu_rdata", cpu_rdata, last_rd[0]);
      chk("dbg_rdata", dbg_rdata, last_rd[1]);
      prev_busy = busy; prev_req = req;
    end
  end
  initial begin
    bit hit = 0;
    addr_i[0] = 0; addr_i[1] = 0; wdata_i[0] = 0; wdata_i[1] = 0;
    for (int i = 0; i < L; i++) pipe[i] = 0;
    pmem[32'h10] = 32'hDEADBEEF; mdl[32'h10] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 rst_checks("reset");
    rst = 0;
    do_txn(0, 0, 32'h10, 0, 0);
    chk("cpu_read_deadbeef", cpu_rdata, 32'hDEADBEEF);
    do_txn(1, 1, 32'h40, 32'h12345678, 0);
    do_txn(1, 0, 32'h40, 0, 0);
    do_txn(0, 0, 32'h40, 0, 1);
    do_txn(0, 1, 32'h44, 32'hCAFEF00D, 1);
    fork
      rand_txns(0, 8, 0);
      rand_txns(1, 8, 0);
    join
    fork
      rand_txns(0, 30, 3);
      rand_txns(1, 30, 3);
    join
    q[0].push_back('{1'b0, 32'h10, 32'h0, md_rd(32'h10)});
    req[0] = 1; we_i[0] = 0; addr_i[0] = 32'h10;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(posedge clk); #1;
      hit = gnt[0] && busy && !mem_en && !cpu_ack;
    end
    chk("reach_wait", hit, 1);
    #2 rst = 1; req[0] = 0;
    #1 rst_checks("abort");
    @(posedge clk); #1 rst_checks("abort_hold");
    rst = 0;
    do_txn(0, 0, 32'h10, 0, 0);
    chk("reissue_rdata", cpu_rdata, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end
endmodule
